// File: rtl/nes_flash_pkg.sv
// Shared definitions for the NOR flash read controller: FSM state encoding,
// default timing constants and a small helper for sizing the cycle counter.
package nes_flash_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    RST_REC  = 3'd1,
    IDLE     = 3'd2,
    ACCESS   = 3'd3,
    RECOVER  = 3'd4
  } flash_state_e;

  localparam int DEF_ADDR_W      = 23;
  localparam int DEF_ACC_CYC     = 7;
  localparam int DEF_REC_CYC     = 1;
  localparam int DEF_RST_CYC     = 50;
  localparam int DEF_RST_REC_CYC = 20;

  // Largest of four cycle counts; sizes the shared state counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/nes_flash_lastbuf.sv
// One-entry last-address buffer: remembers the most recent flash address and
// its data byte so an immediate re-read can be served without touching flash.
module nes_flash_lastbuf
  import nes_flash_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inval,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_lk_addr,
  output logic              o_hit,
  output logic [7:0]        o_data
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  // A fill beats an invalidate in the same cycle: the fill's address was
  // latched before the mapping change and its data is the fresh flash read.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (i_wr_en) begin
      valid_d = 1'b1;
      addr_d  = i_wr_addr;
      data_d  = i_wr_data;
    end else if (i_inval) begin
      valid_d = 1'b0;
    end
  end

  // Buffer storage; reset leaves the entry invalid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_hit  = valid_q && (addr_q == i_lk_addr);
  assign o_data = data_q;

endmodule

// File: rtl/nes_flash_rd_ctrl.sv
// Read sequencer for the cartridge NOR flash. Runs the power-up reset
// sequence, then serves mapper reads either from the last-address buffer
// (one cycle) or with a timed CE#/OE# access followed by a recovery gap.
//
// Handshake: i_rd_req is only looked at in a cycle where o_busy=0; a request
// raised while busy is dropped and must be re-asserted. Each accepted request
// produces exactly one o_rd_valid pulse, with o_fl_rdata valid in that cycle
// and held until the next capture.
module nes_flash_rd_ctrl
  import nes_flash_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int ACC_CYC     = DEF_ACC_CYC,
  parameter int REC_CYC     = DEF_REC_CYC,
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int RST_REC_CYC = DEF_RST_REC_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_fl_addr,
  input  logic              i_rd_req,
  input  logic              i_inval,
  output logic              o_busy,
  output logic              o_rd_valid,
  output logic [7:0]        o_fl_rdata,
  output logic [ADDR_W-1:0] o_flash_addr,
  input  logic [7:0]        i_flash_dq,
  output logic              o_flash_ce_n,
  output logic              o_flash_oe_n,
  output logic              o_flash_we_n,
  output logic              o_flash_rst_n,
  output logic [2:0]        o_dbg_state
);

  localparam int CNT_W = $clog2(max4(ACC_CYC, REC_CYC, RST_CYC, RST_REC_CYC)) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] RREC_LAST = CNT_W'(RST_REC_CYC - 1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_CYC - 1);

  flash_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              ce_n_q, ce_n_d;
  logic              rst_n_q, rst_n_d;

  logic              buf_hit;
  logic [7:0]        buf_data;
  logic              buf_wr;
  logic              lookup_hit;

  nes_flash_lastbuf #(
    .ADDR_W (ADDR_W)
  ) u_lastbuf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inval   (i_inval),
    .i_wr_en   (buf_wr),
    .i_wr_addr (faddr_q),
    .i_wr_data (i_flash_dq),
    .i_lk_addr (i_fl_addr),
    .o_hit     (buf_hit),
    .o_data    (buf_data)
  );

  // An invalidate arriving with the request must already count as a miss.
  assign lookup_hit = buf_hit && !i_inval;

  // Next-state, counter and datapath decisions for the read sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    faddr_d    = faddr_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    buf_wr     = 1'b0;
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = RST_REC;
          cnt_d   = '0;
        end
      end
      RST_REC: begin
        if (cnt_q == RREC_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (i_rd_req) begin
          if (lookup_hit) begin
            rd_valid_d = 1'b1;
            rdata_d    = buf_data;
          end else begin
            faddr_d = i_fl_addr;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == ACC_LAST) begin
          rdata_d    = i_flash_dq;
          rd_valid_d = 1'b1;
          buf_wr     = 1'b1;
          state_d    = RECOVER;
          cnt_d      = '0;
        end
      end
      RECOVER: begin
        if (cnt_q == REC_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Flash pin levels are registered from the next state so they never glitch.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ce_n_d  = (state_d != ACCESS);
    rst_n_d = (state_d != RST_HOLD);
  end

  // State, counter and output registers; reset aborts any access immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= RST_HOLD;
      cnt_q      <= '0;
      faddr_q    <= '0;
      rdata_q    <= 8'h00;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
      ce_n_q     <= 1'b1;
      rst_n_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      faddr_q    <= faddr_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      ce_n_q     <= ce_n_d;
      rst_n_q    <= rst_n_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_fl_rdata    = rdata_q;
  assign o_flash_addr  = faddr_q;
  assign o_flash_ce_n  = ce_n_q;
  assign o_flash_oe_n  = ce_n_q;
  assign o_flash_we_n  = 1'b1;
  assign o_flash_rst_n = rst_n_q;
  assign o_dbg_state   = state_q;

endmodule
